// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller slice.
//   - OP_* : 3-bit branch op encodings driven by the instruction decoder.
//   - depth_w() : width of a stack occupancy count able to hold 0..depth.
//   - DEPTH_W : that width for the default four-entry return stack.
package branch_pkg;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_JC   = 3'd4;
  localparam logic [2:0] OP_JNC  = 3'd5;
  localparam logic [2:0] OP_CALL = 3'd6;
  localparam logic [2:0] OP_RET  = 3'd7;

  // One extra bit over log2 so that "completely full" is representable.
  function automatic int depth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEPTH_W = depth_w(4);

endpackage

// File: rtl/branch_ctrl_ret_stack.sv
// Return-address LIFO: a register array plus an occupancy counter.
// Ports:
//   clk, rst      : clock and asynchronous active-low reset (counter only)
//   push, pop     : requests; ignored when full / empty respectively
//   push_data     : address written on a push
//   top_data      : most recently pushed entry (valid when !empty)
//   full, empty   : occupancy flags
//   depth         : number of valid entries, 0..DEPTH
module ret_stack
  import branch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ADDR_W-1:0]           push_data,
  output logic [ADDR_W-1:0]           top_data,
  output logic                        full,
  output logic                        empty,
  output logic [depth_w(DEPTH)-1:0]   depth
);

  localparam int DW = depth_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]     depth_q, depth_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Next free slot is the low bits of the count; the top is one below it.
  // When full the low bits wrap to 0, so top_idx correctly lands on DEPTH-1.
  assign wr_idx  = depth_q[AW-1:0];
  assign top_idx = depth_q[AW-1:0] - AW'(1);
  assign top_data = mem_q[top_idx];
  assign depth    = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_idx] = push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) depth_q <= '0;
    else      depth_q <= depth_d;
  end

  // Entry contents carry no reset; depth alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_ctrl.sv
// Program counter and branch-decision unit.
// Ports:
//   clk, rst     : clock and asynchronous active-low reset
//   en           : advance strobe; 0 holds PC/stack and drops taken
//   op           : branch op (OP_* in branch_pkg)
//   target       : jump / call destination
//   z_flag,c_flag: registered flags, sampled together with op
//   err_clr      : clears the sticky stack_err (a same-cycle new error wins)
//   pc_out       : current program counter
//   taken        : pulse, previous enabled op redirected the PC
//   stack_depth  : valid return-stack entries
//   stack_err    : sticky overflow / underflow indicator
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [2:0]                        op,
  input  logic [ADDR_W-1:0]                 target,
  input  logic                              z_flag,
  input  logic                              c_flag,
  input  logic                              err_clr,
  output logic [ADDR_W-1:0]                 pc_out,
  output logic                              taken,
  output logic [depth_w(STACK_DEPTH)-1:0]   stack_depth,
  output logic                              stack_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] top_data;
  logic              push, pop, full, empty;
  logic              cond;

  assign seq = pc_q + ADDR_W'(1);

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty),
    .depth     (stack_depth)
  );

  always_comb begin
    cond = 1'b0;
    case (op)
      OP_JZ:   cond = z_flag;
      OP_JNZ:  cond = !z_flag;
      OP_JC:   cond = c_flag;
      OP_JNC:  cond = !c_flag;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    // Clear first so that an error raised below overrides it.
    err_d   = err_q && !err_clr;
    if (en) begin
      case (op)
        OP_JMP: begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
          pc_d    = cond ? target : seq;
          taken_d = cond;
        end
        OP_CALL: begin
          if (!full) begin
            push    = 1'b1;
            pc_d    = target;
            taken_d = 1'b1;
          end else begin
            pc_d  = seq;
            err_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pop     = 1'b1;
            pc_d    = top_data;
            taken_d = 1'b1;
          end else begin
            pc_d  = seq;
            err_d = 1'b1;
          end
        end
        default: pc_d = seq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= ADDR_W'(RESET_PC);
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  assign pc_out    = pc_q;
  assign taken     = taken_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  import branch_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] op = OP_NEXT;
  logic [7:0] target = 8'h00;
  logic       z_flag = 1'b0;
  logic       c_flag = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] pc_out;
  logic       taken;
  logic [2:0] stack_depth;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  branch_ctrl #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .target(target),
    .z_flag(z_flag), .c_flag(c_flag), .err_clr(err_clr),
    .pc_out(pc_out), .taken(taken), .stack_depth(stack_depth),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, stack as a queue.
  int         m_pc = 0;
  logic [7:0] m_stack[$];
  bit         m_taken = 0;
  bit         m_err = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 0; m_stack.delete(); m_taken = 0; m_err = 0;
    end else begin
      int  nxt;
      bit  ok;
      nxt = (m_pc + 1) % 256;
      if (err_clr) m_err = 0;
      m_taken = 0;
      if (en) begin
        case (op)
          OP_JMP: begin m_pc = target; m_taken = 1; end
          OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
            ok = (op == OP_JZ)  ? z_flag :
                 (op == OP_JNZ) ? !z_flag :
                 (op == OP_JC)  ? c_flag : !c_flag;
            if (ok) begin m_pc = target; m_taken = 1; end
            else m_pc = nxt;
          end
          OP_CALL: begin
            if (m_stack.size() < 4) begin
              m_stack.push_back(8'(nxt)); m_pc = target; m_taken = 1;
            end else begin
              m_pc = nxt; m_err = 1;
            end
          end
          OP_RET: begin
            if (m_stack.size() > 0) begin
              m_pc = m_stack.pop_back(); m_taken = 1;
            end else begin
              m_pc = nxt; m_err = 1;
            end
          end
          default: m_pc = nxt;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_pc", pc_out, m_pc);
    chk("model_taken", taken, m_taken);
    chk("model_depth", stack_depth, m_stack.size());
    chk("model_err", stack_err, m_err);
  end

  // Drive one cycle of inputs at a negedge, return at the next negedge.
  task automatic go(input bit e, input logic [2:0] o, input logic [7:0] t,
                    input bit z = 0, input bit c = 0, input bit clr = 0);
    en = e; op = o; target = t; z_flag = z; c_flag = c; err_clr = clr;
    @(negedge clk);
    en = 0; err_clr = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_pc", pc_out, 0);
    chk("reset_taken", taken, 0);
    chk("reset_depth", stack_depth, 0);
    chk("reset_err", stack_err, 0);
    rst = 1;

    go(1, OP_NEXT, 0); chk("next1", pc_out, 1);
    go(1, OP_NEXT, 0); chk("next2", pc_out, 2);
    go(1, OP_NEXT, 0); chk("next3", pc_out, 3); chk("next_taken", taken, 0);

    // Asynchronous reset in the middle of the low phase.
    #2 rst = 0;
    #1 chk("async_rst_pc", pc_out, 0);
    @(negedge clk); rst = 1;

    repeat (5) go(1, OP_NEXT, 0);
    chk("pc5", pc_out, 5);
    go(1, OP_JZ, 8'h40, 0); chk("jz_false_pc", pc_out, 6); chk("jz_false_tk", taken, 0);
    go(1, OP_JZ, 8'h40, 1); chk("jz_true_pc", pc_out, 8'h40); chk("jz_true_tk", taken, 1);
    go(1, OP_NEXT, 0);      chk("pulse_end_tk", taken, 0); chk("pulse_end_pc", pc_out, 8'h41);

    go(1, OP_JMP, 8'h10);
    go(1, OP_JC, 8'h80, 0, 1);  chk("jc_true", pc_out, 8'h80);
    go(1, OP_JMP, 8'h10);
    go(1, OP_JNC, 8'h80, 0, 1); chk("jnc_false", pc_out, 8'h11);
    go(1, OP_JNZ, 8'h22, 0);    chk("jnz_true", pc_out, 8'h22);
    go(1, OP_JMP, 8'hFF);
    go(1, OP_NEXT, 0);          chk("wrap", pc_out, 8'h00);

    // Nested calls.
    go(1, OP_JMP, 8'h03);
    go(1, OP_CALL, 8'h20); chk("call1_pc", pc_out, 8'h20); chk("call1_d", stack_depth, 1);
    go(1, OP_CALL, 8'h30); chk("call2_pc", pc_out, 8'h30); chk("call2_d", stack_depth, 2);
    go(1, OP_RET, 0);      chk("ret1_pc", pc_out, 8'h21);  chk("ret1_d", stack_depth, 1);
    go(1, OP_RET, 0);      chk("ret2_pc", pc_out, 8'h04);  chk("ret2_d", stack_depth, 0);
    chk("nest_err", stack_err, 0);

    // Overflow.
    repeat (4) go(1, OP_CALL, 8'h50);
    chk("full_d", stack_depth, 4);
    go(1, OP_CALL, 8'h60); chk("ovf_pc", pc_out, 8'h51); chk("ovf_d", stack_depth, 4);
    chk("ovf_err", stack_err, 1); chk("ovf_tk", taken, 0);
    go(0, OP_NEXT, 0, 0, 0, 1); chk("clr_err", stack_err, 0); chk("clr_pc", pc_out, 8'h51);
    repeat (3) go(1, OP_RET, 0);
    go(1, OP_RET, 0); chk("drain_pc", pc_out, 8'h05); chk("drain_d", stack_depth, 0);

    // Underflow.
    go(1, OP_RET, 0); chk("unf_pc", pc_out, 8'h06); chk("unf_err", stack_err, 1);
    chk("unf_tk", taken, 0);
    go(1, OP_RET, 0, 0, 0, 1); chk("unf_clr_err", stack_err, 1); chk("unf_clr_pc", pc_out, 8'h07);
    go(1, OP_JMP, 8'h90);
    repeat (3) go(0, OP_JMP, 8'hAA);
    chk("hold_pc", pc_out, 8'h90); chk("hold_tk", taken, 0); chk("hold_err", stack_err, 1);

    // CALL to own address still pushes seq.
    go(1, OP_CALL, 8'h90); chk("self_call_pc", pc_out, 8'h90); chk("self_call_d", stack_depth, 1);
    go(1, OP_RET, 0);      chk("self_ret_pc", pc_out, 8'h91);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
